// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, label limit, stack depth and enums for the PC sequencer
package pc_pkg;
  localparam int PC_W        = 12;
  localparam int LABEL_W     = 8;
  localparam int NUM_LABELS  = 44;
  localparam int STACK_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_LABEL, ERR_OVERRUN, ERR_STACK} err_e;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses with push/pop, clear and full/empty flags
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;
  assign full  = ptr == AW'(DEPTH);
  assign empty = ptr == '0;
  assign dout  = mem[IW'(ptr - 1'b1)];
  always_ff @(posedge clk) begin
    if (rst || clr) ptr <= '0;
    else if (push && !full) begin
      mem[IW'(ptr)] <= din;
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) ptr <= ptr - 1'b1;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC and start/done handshake; call/return stack enabled by PC_CALL_STACK_EN
module pc_sequencer
  import pc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               halt,
  input  logic               branch,
  input  logic               taken,
  input  logic               call,
  input  logic               ret,
  input  logic [LABEL_W-1:0] label,
  output logic [LABEL_W-1:0] lut_label,
  input  logic [PC_W-1:0]    lut_target,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic [1:0]         err
);
  seq_state_e state, state_n;
  err_e err_q, err_n;
  logic [PC_W-1:0] pc_n;
  logic label_ok, jump;
  assign lut_label = label;
  assign err       = err_q;
  assign label_ok  = label < LABEL_W'(NUM_LABELS);
  // ret outranks call, so a simultaneous ret suppresses the jump
  assign jump      = !ret && (call || (branch && taken));
`ifdef PC_CALL_STACK_EN
  logic push, pop, clr, full, empty;
  logic [PC_W-1:0] top;
  assign clr = start && state != RUN;
  ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk(clk), .rst(reset), .clr(clr), .push(push), .pop(pop),
    .din(pc + 1'b1), .dout(top), .full(full), .empty(empty)
  );
`endif
  always_comb begin
    state_n = state;
    pc_n    = pc;
    err_n   = err_q;
`ifdef PC_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state)
      IDLE: begin
        pc_n    = '0;
        state_n = start ? RUN : IDLE;
      end
      RUN: begin
        if (stall) state_n = RUN;
        else if (halt) state_n = DONE;
`ifdef PC_CALL_STACK_EN
        else if (ret) begin
          state_n = empty ? DONE : RUN;
          err_n   = empty ? ERR_STACK : err_q;
          pc_n    = empty ? pc : top;
          pop     = !empty;
        end
`endif
        else if (jump) begin
          if (!label_ok) begin
            state_n = DONE;
            err_n   = ERR_LABEL;
          end
`ifdef PC_CALL_STACK_EN
          else if (call && full) begin
            state_n = DONE;
            err_n   = ERR_STACK;
          end
`endif
          else begin
            pc_n = lut_target;
`ifdef PC_CALL_STACK_EN
            push = call;
`endif
          end
        end else if (pc == '1) begin
          state_n = DONE;
          err_n   = ERR_OVERRUN;
        end else pc_n = pc + 1'b1;
      end
      DONE: begin
        state_n = start ? RUN : DONE;
        pc_n    = start ? '0 : pc;
        err_n   = start ? ERR_NONE : err_q;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      err_q <= ERR_NONE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      err_q <= err_n;
      done  <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus call/return sequences for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stall = 1'b0, halt = 1'b0;
  logic branch = 1'b0, taken = 1'b0, call = 1'b0, ret = 1'b0;
  logic [7:0] label = '0, lut_label;
  logic [11:0] lut_target = '0, pc;
  logic done;
  logic [1:0] err;
  int checks = 0, errors = 0;

  typedef struct {
    logic rst, st, sl, hl, br, tk, cl, rt;
    logic [7:0] lbl;
    logic [11:0] tgt, epc;
    logic edone;
    logic [1:0] eerr;
  } vec_t;

  vec_t tbl[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch(branch), .taken(taken), .call(call), .ret(ret), .label(label),
    .lut_label(lut_label), .lut_target(lut_target), .pc(pc), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic rst, st, sl, hl, br, tk, cl, rt, int lbl, int tgt, int epc, logic edone, int eerr);
    vec_t r;
    r.rst = rst; r.st = st; r.sl = sl; r.hl = hl; r.br = br; r.tk = tk; r.cl = cl; r.rt = rt;
    r.lbl = 8'(lbl); r.tgt = 12'(tgt); r.epc = 12'(epc); r.edone = edone; r.eerr = 2'(eerr);
    return r;
  endfunction

  task automatic check(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t x, int idx);
    @(negedge clk);
    reset = x.rst; start = x.st; stall = x.sl; halt = x.hl; branch = x.br;
    taken = x.tk; call = x.cl; ret = x.rt; label = x.lbl; lut_target = x.tgt;
    #1 check("lut_label", idx, int'(lut_label), int'(x.lbl));
    @(posedge clk);
    #1;
    check("pc", idx, int'(pc), int'(x.epc));
    check("done", idx, int'(done), int'(x.edone));
    check("err", idx, int'(err), int'(x.eerr));
  endtask

  initial begin
    //            rst st sl hl br tk cl rt lbl  tgt   pc  dn er
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    2, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    3, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    4, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    5, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0,  0,    0,    5, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    5, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    2, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    3, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,  2,  355,  355, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,  5,    3,    3, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,  2,  355,    4, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 50,  100,    4, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    4, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 0, 0,  1,   77,    0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 0, 0,  1,   77,    0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 0, 0,  1,   77,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0,  0,    0,    0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 43, 4095, 4095, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0, 4095, 1, 2));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 44,    9,    0, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,  0,    0,    0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  0,    0,    1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,  0,    0,    2, 0, 0));
    foreach (tbl[i]) apply(tbl[i], i);
`ifdef PC_CALL_STACK_EN
    apply(v(0, 0, 0, 0, 1, 1, 0, 0,  0,  10,  10, 0, 0), 100);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0, 18,   8,   8, 0, 0), 101);
    apply(v(0, 0, 0, 0, 0, 0, 0, 0,  0,   0,   9, 0, 0), 102);
    apply(v(0, 0, 0, 0, 0, 0, 0, 1,  0,   0,  11, 0, 0), 103);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0,  1, 100, 100, 0, 0), 104);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0,  1, 200, 200, 0, 0), 105);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0,  1, 300, 300, 0, 0), 106);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0,  1, 400, 400, 0, 0), 107);
    apply(v(0, 0, 0, 0, 0, 0, 0, 1,  0,   0, 301, 0, 0), 108);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0,  1, 400, 400, 0, 0), 109);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0,  1, 500, 400, 1, 3), 110);
    apply(v(0, 1, 0, 0, 0, 0, 0, 0,  0,   0,   0, 0, 0), 111);
    apply(v(0, 0, 0, 0, 0, 0, 0, 1,  0,   0,   0, 1, 3), 112);
    apply(v(0, 1, 0, 0, 0, 0, 0, 0,  0,   0,   0, 0, 0), 113);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0, 60,   5,   0, 1, 1), 114);
`else
    apply(v(0, 0, 0, 0, 1, 1, 0, 0,  0,  10,  10, 0, 0), 100);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0, 18,   8,   8, 0, 0), 101);
    apply(v(0, 0, 0, 0, 0, 0, 0, 1,  0,   0,   9, 0, 0), 102);
    apply(v(0, 0, 0, 0, 0, 0, 1, 1,  3,  50,  10, 0, 0), 103);
    apply(v(0, 0, 0, 0, 1, 1, 0, 0,  0, 4095, 4095, 0, 0), 104);
    apply(v(0, 0, 0, 0, 0, 0, 0, 1,  0,   0, 4095, 1, 2), 105);
    apply(v(0, 1, 0, 0, 0, 0, 0, 0,  0,   0,   0, 0, 0), 106);
    apply(v(0, 0, 0, 0, 0, 0, 1, 0, 44,   5,   0, 1, 1), 107);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
